fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arb_pkg.sv | 24 ++
 rtl/fb_arb_if.sv | 45 ++++
 rtl/fb_rd_tag_pipe.sv | 38 +++
 rtl/fb_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Framebuffer arbiter shared types and default constants.
// Owner tags label each memory read so its data is routed back to the right port.
package fb_arb_pkg;

  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 8;
  localparam int MAX_ADDR     = 76799;
  localparam int RD_LAT       = 2;
  localparam int STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VGA,
    S_ALG,
    S_FORCE_ALG
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_ALG
  } owner_e;

endpackage

// File: rtl/fb_arb_if.sv
// Framebuffer arbiter bus: VGA read port, algorithm port, memory port.
// slave is the arbiter's view, master is the surrounding system's view.
interface fb_arb_if #(
  parameter int ADDR_W = fb_arb_pkg::ADDR_W,
  parameter int DATA_W = fb_arb_pkg::DATA_W
) ();

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic              alg_req;
  logic              alg_we;
  logic [ADDR_W-1:0] alg_addr;
  logic [DATA_W-1:0] alg_wdata;
  logic              alg_ack;
  logic              alg_err;
  logic [DATA_W-1:0] alg_rdata;
  logic              alg_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr,
    output vga_rdata, vga_rvalid,
    input  alg_req, alg_we, alg_addr, alg_wdata,
    output alg_ack, alg_err, alg_rdata, alg_rvalid,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_q
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_rdata, vga_rvalid,
    output alg_req, alg_we, alg_addr, alg_wdata,
    input  alg_ack, alg_err, alg_rdata, alg_rvalid,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_q
  );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Owner-tag delay line matching the memory read latency.
// Carries who issued each read and whether it was out of range.
module fb_rd_tag_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  fb_arb_pkg::owner_e tag_i,
  input  logic               oor_i,
  output fb_arb_pkg::owner_e tag_o,
  output logic               oor_o
);
  import fb_arb_pkg::*;

  owner_e            tag_q [RD_LAT];
  logic [RD_LAT-1:0] oor_q;

  // shift tags one stage per cycle; reset drops reads in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
      oor_q <= '0;
    end else begin
      tag_q[0] <= tag_i;
      oor_q[0] <= oor_i;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
        oor_q[i] <= oor_q[i-1];
      end
    end
  end

  assign tag_o = tag_q[RD_LAT-1];
  assign oor_o = oor_q[RD_LAT-1];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA reads vs. algorithm reads/writes.
// VGA has priority; a starving algorithm request is forced through.
module fb_arbiter #(
  parameter int ADDR_W       = fb_arb_pkg::ADDR_W,
  parameter int DATA_W       = fb_arb_pkg::DATA_W,
  parameter int MAX_ADDR     = fb_arb_pkg::MAX_ADDR,
  parameter int RD_LAT       = fb_arb_pkg::RD_LAT,
  parameter int STARVE_LIMIT = fb_arb_pkg::STARVE_LIMIT
) (
  input logic   clock,
  input logic   reset,
  fb_arb_if.slave bus
);
  import fb_arb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);
  localparam logic [3:0]        SLIM = 4'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;

  logic              alg_live;
  logic              alg_bad;
  logic              vga_bad;
  logic              force_alg;
  logic              alg_win;
  logic              alg_eacc;
  logic              vga_win;

  owner_e            iss_tag;
  owner_e            ret_tag;
  logic              ret_oor;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] vga_hold_q;
  logic [DATA_W-1:0] alg_hold_q;
  logic              vga_rv;
  logic              alg_rv;

  // same-cycle arbitration and next-command selection
  always_comb begin
    alg_live  = bus.alg_req & ~ack_q;
    alg_bad   = bus.alg_addr > LAST;
    vga_bad   = bus.vga_addr > LAST;
    force_alg = starve_q == SLIM;
    alg_eacc  = alg_live & alg_bad;
    alg_win   = alg_live & ~alg_bad
              & (~bus.vga_req | force_alg);
    vga_win   = bus.vga_req & ~alg_win;

    state_d = S_IDLE;
    ack_d   = alg_win | alg_eacc;
    err_d   = alg_eacc;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = 1'b0;

    unique case (1'b1)
      alg_win: begin
        state_d = (force_alg & bus.vga_req)
                ? S_FORCE_ALG : S_ALG;
        addr_d  = bus.alg_addr;
        if (bus.alg_we) begin
          wren_d  = 1'b1;
          wdata_d = bus.alg_wdata;
        end
      end
      vga_win: begin
        state_d = S_VGA;
        oor_d   = vga_bad;
        if (!vga_bad) begin
          addr_d = bus.vga_addr;
        end
      end
      default: ;
    endcase

    // an error ack does not use the memory, so fairness is untouched
    if (!alg_live || alg_win) begin
      starve_d = 4'd0;
    end else if (alg_eacc || starve_q == SLIM) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 4'd1;
    end
  end

  // owner FSM and registered memory command
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      starve_q <= 4'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oor_q    <= oor_d;
    end
  end

  // tag of the command currently on the memory port
  always_comb begin
    case (state_q)
      S_VGA:       iss_tag = OWN_VGA;
      S_ALG,
      S_FORCE_ALG: iss_tag = wren_q ? OWN_NONE : OWN_ALG;
      default:     iss_tag = OWN_NONE;
    endcase
  end

  fb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .tag_i (iss_tag),
    .oor_i (oor_q),
    .tag_o (ret_tag),
    .oor_o (ret_oor)
  );

  assign vga_rv   = ret_tag == OWN_VGA;
  assign alg_rv   = ret_tag == OWN_ALG;
  assign ret_data = ret_oor ? '0 : bus.mem_q;

  // keep the last returned value on each port
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga_hold_q <= '0;
      alg_hold_q <= '0;
    end else begin
      if (vga_rv) vga_hold_q <= ret_data;
      if (alg_rv) alg_hold_q <= ret_data;
    end
  end

  assign bus.vga_rvalid = vga_rv;
  assign bus.vga_rdata  = vga_rv ? ret_data : vga_hold_q;
  assign bus.alg_rvalid = alg_rv;
  assign bus.alg_rdata  = alg_rv ? ret_data : alg_hold_q;
  assign bus.alg_ack    = ack_q;
  assign bus.alg_err    = err_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wren   = wren_q;

endmodule
